// File: rtl/gate_function_identifier.sv
// Characterises an unknown 2-input gate by sweeping {a,b} and decoding the sampled truth table.
// Latency: 4*SETTLE_CYCLES*PASSES cycles from the accepted start edge to the done pulse.
// Backpressure: none; start is ignored while busy and accepted again during the done cycle.
module gate_function_identifier #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       probe_a,
    output logic       probe_b,
    input  logic       probe_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth,
    output logic [2:0] func,
    output logic       unstable
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int PW = $clog2(PASSES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    k_q, k_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [3:0]    shadow_q, shadow_d;
    logic          mism_q, mism_d;
    logic [3:0]    truth_q, truth_d;
    logic [2:0]    func_q, func_d;
    logic          unstable_q, unstable_d;

    // Map a sampled truth table to a function code; any inconsistency forces OTHER.
    function automatic logic [2:0] decode(input logic [3:0] t, input logic u);
        logic [2:0] code;
        case (t)
            4'b0000: code = 3'd0;
            4'b1000: code = 3'd1;
            4'b1110: code = 3'd2;
            4'b0111: code = 3'd3;
            4'b0001: code = 3'd4;
            4'b0110: code = 3'd5;
            4'b1001: code = 3'd6;
            default: code = 3'd7;
        endcase
        return u ? 3'd7 : code;
    endfunction

    // Next-state, sampling and output logic for the sweep controller.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        settle_d   = settle_q;
        pass_d     = pass_q;
        shadow_d   = shadow_q;
        mism_d     = mism_q;
        truth_d    = truth_q;
        func_d     = func_q;
        unstable_d = unstable_q;
        probe_a    = 1'b0;
        probe_b    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE, FINISH: begin
                done = (state_q == FINISH);
                if (start) begin
                    state_d  = SWEEP;
                    k_d      = 2'd0;
                    settle_d = '0;
                    pass_d   = '0;
                    mism_d   = 1'b0;
                end else begin
                    state_d  = IDLE;
                end
            end
            SWEEP: begin
                busy               = 1'b1;
                {probe_a, probe_b} = k_q;
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    // Pass 0 records the reference; later passes only check against it.
                    if (pass_q == '0) begin
                        shadow_d[k_q] = probe_y;
                    end else if (probe_y != shadow_q[k_q]) begin
                        mism_d = 1'b1;
                    end
                    k_d = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        if (pass_q == PASS_LAST) begin
                            // Results publish on the final sample edge, so use the _d views.
                            state_d    = FINISH;
                            truth_d    = shadow_d;
                            unstable_d = mism_d;
                            func_d     = decode(shadow_d, mism_d);
                        end else begin
                            pass_d = pass_q + PW'(1);
                        end
                    end
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset that also clears published results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= 2'd0;
            settle_q   <= '0;
            pass_q     <= '0;
            shadow_q   <= 4'd0;
            mism_q     <= 1'b0;
            truth_q    <= 4'd0;
            func_q     <= 3'd0;
            unstable_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            settle_q   <= settle_d;
            pass_q     <= pass_d;
            shadow_q   <= shadow_d;
            mism_q     <= mism_d;
            truth_q    <= truth_d;
            func_q     <= func_d;
            unstable_q <= unstable_d;
        end
    end

    assign truth    = truth_q;
    assign func     = func_q;
    assign unstable = unstable_q;

endmodule

// File: tb/tb_gate_function_identifier.sv
// Bench for the gate characteriser: one default instance and one SETTLE=1/PASSES=1 instance.
// Each instance faces a bench-modelled gate; a timeline model predicts every output each cycle.
// Directed runs additionally pin latency and decoded results with literal values.
module tb_gate_function_identifier;

    localparam int S0 = 2;
    localparam int P0 = 2;
    localparam int S1 = 1;
    localparam int P1 = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] pa, pb, py, busy_w, done_w, uns_w;
    logic [3:0] truth_w [2];
    logic [2:0] func_w  [2];

    logic [3:0] tt     [2];
    logic       glitch [2];

    int m [2] = '{-1, -1};
    logic [3:0] et [2];
    logic [2:0] ef [2];
    logic       eu [2];
    logic       model_ok = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gate_function_identifier #(.SETTLE_CYCLES(S0), .PASSES(P0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .probe_a(pa[0]), .probe_b(pb[0]), .probe_y(py[0]),
        .busy(busy_w[0]), .done(done_w[0]),
        .truth(truth_w[0]), .func(func_w[0]), .unstable(uns_w[0])
    );

    gate_function_identifier #(.SETTLE_CYCLES(S1), .PASSES(P1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .probe_a(pa[1]), .probe_b(pb[1]), .probe_y(py[1]),
        .busy(busy_w[1]), .done(done_w[1]),
        .truth(truth_w[1]), .func(func_w[1]), .unstable(uns_w[1])
    );

    function automatic int s_of(input int i);
        return (i == 0) ? S0 : S1;
    endfunction

    function automatic int p_of(input int i);
        return (i == 0) ? P0 : P1;
    endfunction

    // Named-function table for the known gates.
    function automatic logic [2:0] name_of(input logic [3:0] t);
        case (t)
            4'b0000: return 3'd0;
            4'b1000: return 3'd1;
            4'b1110: return 3'd2;
            4'b0111: return 3'd3;
            4'b0001: return 3'd4;
            4'b0110: return 3'd5;
            4'b1001: return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    // Gate under test: lookup of the table, optionally inverted at combination 01 of the second pass.
    always_comb begin
        py = 2'b00;
        for (int i = 0; i < 2; i++) begin
            py[i] = tt[i][{pa[i], pb[i]}];
            if (glitch[i] && m[i] >= 0 && (m[i] / (4 * s_of(i))) == 1 && {pa[i], pb[i]} == 2'b01)
                py[i] = ~py[i];
        end
    end

    // Timeline model: m counts edges since the accepting start edge, -1 when idle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m[i]     <= -1;
                et[i]    <= 4'd0;
                ef[i]    <= 3'd0;
                eu[i]    <= 1'b0;
                model_ok <= 1'b1;
            end else begin
                if (m[i] == -1 || m[i] == 4 * s_of(i) * p_of(i))
                    m[i] <= start[i] ? 0 : -1;
                else
                    m[i] <= m[i] + 1;
                if (m[i] == 4 * s_of(i) * p_of(i) - 1) begin
                    et[i] <= tt[i];
                    eu[i] <= glitch[i] && (p_of(i) > 1);
                    ef[i] <= (glitch[i] && (p_of(i) > 1)) ? 3'd7 : name_of(tt[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: actual=%0d required=%0d", name, idx, $time, act, exp);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 2; i++) begin
                int lat;
                bit act;
                lat = 4 * s_of(i) * p_of(i);
                act = (m[i] >= 0) && (m[i] < lat);
                chk("busy", i, int'(busy_w[i]), int'(act));
                chk("done", i, int'(done_w[i]), int'(m[i] == lat));
                chk("probes", i, int'({pa[i], pb[i]}), act ? (m[i] / s_of(i)) % 4 : 0);
                chk("truth", i, int'(truth_w[i]), int'(et[i]));
                chk("func", i, int'(func_w[i]), int'(ef[i]));
                chk("unstable", i, int'(uns_w[i]), int'(eu[i]));
            end
        end
    end

    // Pulse start for one cycle, then count cycles until done (bounded).
    task automatic run(input int i, output int lat);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
        lat = 0;
        while (!done_w[i] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic wait_done(input int i, inout int lat);
        while (!done_w[i] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        start = 2'b00;
        tt[0] = 4'b0000; tt[1] = 4'b0000;
        glitch[0] = 1'b0; glitch[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_truth", 0, int'(truth_w[0]), 0);
        chk("reset_busy", 0, int'(busy_w[0]), 0);

        // AND
        tt[0] = 4'b1000;
        run(0, lat);
        chk("and_latency", 0, lat, 16);
        chk("and_truth", 0, int'(truth_w[0]), 8);
        chk("and_func", 0, int'(func_w[0]), 1);
        chk("and_unstable", 0, int'(uns_w[0]), 0);

        // XNOR
        tt[0] = 4'b1001;
        run(0, lat);
        chk("xnor_truth", 0, int'(truth_w[0]), 9);
        chk("xnor_func", 0, int'(func_w[0]), 6);

        // y = ~a
        tt[0] = 4'b0011;
        run(0, lat);
        chk("nota_truth", 0, int'(truth_w[0]), 3);
        chk("nota_func", 0, int'(func_w[0]), 7);

        // constant 0
        tt[0] = 4'b0000;
        run(0, lat);
        chk("const0_func", 0, int'(func_w[0]), 0);

        // OR with a disagreeing second pass at combination 01
        tt[0] = 4'b1110;
        glitch[0] = 1'b1;
        run(0, lat);
        chk("glitch_truth", 0, int'(truth_w[0]), 14);
        chk("glitch_unstable", 0, int'(uns_w[0]), 1);
        chk("glitch_func", 0, int'(func_w[0]), 7);
        @(posedge clk); #1 glitch[0] = 1'b0;

        // Short instance, NOR, start re-asserted mid-run
        tt[1] = 4'b0001;
        @(posedge clk); #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        @(posedge clk); #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        lat = 2;
        wait_done(1, lat);
        chk("nor_latency", 1, lat, 4);
        chk("nor_truth", 1, int'(truth_w[1]), 1);
        chk("nor_func", 1, int'(func_w[1]), 4);

        // Back-to-back: NAND then XOR, second start during the done cycle
        tt[0] = 4'b0111;
        run(0, lat);
        chk("nand_func", 0, int'(func_w[0]), 3);
        start[0] = 1'b1;
        tt[0] = 4'b0110;
        @(posedge clk); #1 start[0] = 1'b0;
        lat = 0;
        wait_done(0, lat);
        chk("b2b_latency", 0, lat, 16);
        chk("xor_func", 0, int'(func_w[0]), 5);
        chk("xor_truth", 0, int'(truth_w[0]), 6);

        // Reset at cycle 7 of a run
        tt[0] = 4'b1000;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        chk("abort_truth", 0, int'(truth_w[0]), 0);
        chk("abort_func", 0, int'(func_w[0]), 0);
        chk("abort_busy", 0, int'(busy_w[0]), 0);
        chk("abort_done", 0, int'(done_w[0]), 0);
        run(0, lat);
        chk("rerun_latency", 0, lat, 16);
        chk("rerun_func", 0, int'(func_w[0]), 1);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gate_function_identifier.md
# gate_function_identifier

Sequential characteriser for an unknown 2-input, 1-output combinational gate such as the NAND/NOR-built universal gates. On a start request it drives the gate's inputs through all four combinations, waits a programmable settle time, and samples the output at each combination. It repeats the sweep a programmable number of times and assembles a 4-bit truth table. It then decodes the table into a function code and flags outputs that were inconsistent between passes. It is the observing end of the gate interface: it drives `a`/`b` and reads the gate output, where the gate modules consume `a`/`b` and produce outputs.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2: cycles each input combination is held before its output sample is taken; legal range ≥1.
- `PASSES`, default 2: number of full sweeps per run; legal range ≥1.

Ports:
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst_n` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: run request, level-sampled on a rising edge.
- `probe_a` output, 1 bit: drives the gate's `a` input.
- `probe_b` output, 1 bit: drives the gate's `b` input.
- `probe_y` input, 1 bit: the gate output under test.
- `busy` output, 1 bit: high while a run is in progress.
- `done` output, 1 bit: one-cycle pulse when results update.
- `truth` output, 4 bits: `truth[i]` is the `probe_y` value sampled when `{probe_a,probe_b}` = i, taken from pass 1.
- `func` output, 3 bits: decoded function code.
- `unstable` output, 1 bit: a later pass disagreed with pass 1.

## Operation
- FSM states: IDLE, SWEEP, FINISH.
- IDLE:
  - `busy`=0 and probes = 00.
  - `start`=1 on an edge goes to SWEEP. Combination index k=0, settle counter cleared, pass counter cleared, internal mismatch flag cleared.
- SWEEP:
  - Probes hold `{probe_a,probe_b}` = k.
  - The settle counter counts from 0 to SETTLE_CYCLES−1. On the edge where it reaches SETTLE_CYCLES−1, `probe_y` is sampled.
  - In pass 0 the sample is written to shadow truth bit k.
  - In later passes the sample is compared with shadow bit k; a mismatch sets the mismatch flag, which is sticky for the rest of the run.
  - On the same edge k advances. Order is 00, 01, 10, 11, then wrap to 00 with the pass counter incremented.
  - After the sample at k=3 in pass PASSES−1, go to FINISH.
- FINISH (this is the same edge as the final sample; FINISH is a 1-cycle state):
  - `done`=1, `busy`=0, probes = 00.
  - `truth`, `func` and `unstable` load from the shadow registers. These three outputs change only here.
  - The FSM then returns to IDLE.
- `func` decode, with `truth` written as bit3..bit0:
  - 0000 → 0 (CONST0)
  - 1000 → 1 (AND)
  - 1110 → 2 (OR)
  - 0111 → 3 (NAND)
  - 0001 → 4 (NOR)
  - 0110 → 5 (XOR)
  - 1001 → 6 (XNOR)
  - anything else, including CONST1 and single-input functions → 7 (OTHER)
  - If `unstable`=1, `func`=7 regardless of `truth`.
- `start` while `busy`=1 is ignored, including on the edge of the final sample.
- `start` high on the edge following `done` (i.e. during the FINISH cycle) is accepted, giving back-to-back runs.
- Counter widths: settle counter is $clog2(SETTLE_CYCLES+1) bits; pass counter is $clog2(PASSES+1) bits. Neither counter may overflow at the parameter extremes.

## Timing
- Reset (`rst_n`=0 at an edge) forces:
  - `probe_a`=0, `probe_b`=0, `busy`=0, `done`=0
  - `truth`=0000, `func`=000, `unstable`=0
  - FSM to IDLE
- Reset mid-run aborts the run: no `done` pulse, and previous results are cleared to the reset values above.
- Let start be accepted at edge S:
  - `busy`=1 and probes = 00 from S.
  - Sample n (n = 1..4·PASSES) is taken at edge S + n·SETTLE_CYCLES.
  - `done`=1 for exactly the cycle after edge S + 4·SETTLE_CYCLES·PASSES.
- Run latency is 4·SETTLE_CYCLES·PASSES cycles: 16 at defaults, 4 with SETTLE_CYCLES=1 and PASSES=1.
- Each probe combination is stable for exactly SETTLE_CYCLES cycles. There are no glitch cycles between combinations.
- `probe_y` is treated as combinationally dependent on the probes and must settle within SETTLE_CYCLES−1 cycles plus one clock period.

## Test plan
- Gate = AND (y=a&b), defaults, 1-cycle `start` → `done` exactly 16 cycles after the start edge; `truth`=1000, `func`=1, `unstable`=0; `busy` high for 16 cycles.
- Gate = XNOR → `truth`=1001, `func`=6. Gate y=~a → `truth`=0011, `func`=7. Gate y=0 → `truth`=0000, `func`=0.
- Gate = OR, with `probe_y` forced inverted only during combination 01 of pass 2 → `truth`=1110 (from pass 1), `unstable`=1, `func`=7.
- SETTLE_CYCLES=1, PASSES=1, gate = NOR → probes step 00, 01, 10, 11, one cycle each; `done` at +4 cycles; `truth`=0001, `func`=4. Re-asserting `start` at cycle 2 has no effect.
- Back-to-back runs: `start` asserted during the `done` cycle, with the gate switched from NAND to XOR → first run gives `func`=3, second run gives `done` 16 cycles later with `func`=5.
- Reset asserted at cycle 7 of a run → all outputs return to reset values next cycle, no `done`; a new `start` then completes normally in 16 cycles.
